data_mem_responder: RTL
=======================

# data_mem_responder

Memory-side responder for the CPU data port: accepts the CPU's M-stage load/store requests and returns read data in the same cycle. The CPU's M→W pipeline register captures it at the next clock edge. Contains a word-addressed data RAM plus a small memory-mapped register window: cycle counter, output port and sticky error status. Sits between the CPU top level and the board/testbench, as the other end of the CPU data-memory interface.

## Interface
Parameters:
- ADDR_WIDTH, 10, log2 of RAM depth in 32-bit words (RAM = 4·2^ADDR_WIDTH bytes at base 0x0000_0000)
- MMIO_BASE, 32'hFFFF_0000, base byte address of the 32-byte register window

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- data_addr  input  32  byte address from CPU
- mem_read_en  input  1  load request, qualifies data_addr
- mem_write_en  input  1  store request, qualifies data_addr and mem_write_data
- mem_write_data  input  32  store data
- mem_read_data  output  32  load data, combinational from address/enable
- access_err  output  1  combinational: current access is misaligned, unmapped or a read+write collision
- out_port  output  32  OUT register contents
- status  output  3  sticky error bits {collision, unmapped, misaligned}

## Operation
- Decode: RAM hit when data_addr[31:ADDR_WIDTH+2]==0. MMIO hit when data_addr[31:5]==MMIO_BASE[31:5]. Anything else is unmapped.
- Misaligned: data_addr[1:0]!=0 with either enable high. No RAM/MMIO write, read data 0, status[0] set.
- Unmapped (aligned): write dropped, read data 0, status[1] set.
- mem_read_en and mem_write_en both high: status[2] set. Write commits at the edge. Read returns the pre-write value.
- mem_read_en low: mem_read_data = 0.
- RAM: asynchronous read of word data_addr[ADDR_WIDTH+1:2]; synchronous write on the rising edge. RAM contents are not reset.
- MMIO offsets (byte):
  - 0x00 CYCLE: RO; counts every clk edge while rst high; wraps 0xFFFF_FFFF→0.
  - 0x04 OUT: RW; drives out_port.
  - 0x08 STATUS: bits[2:0]; write-1-to-clear per bit. A new error in the same cycle as a clear wins, so the bit stays set.
  - 0x0C LOADS and 0x10 STORES: see Configuration.
  - Other offsets in the window read 0 and ignore writes (not an error).
- Writes to RO registers are ignored.
- Counter and status updates occur on the same edge as the access.

## Timing
- Read latency 0 cycles: mem_read_data is valid within the cycle the enable is asserted.
- Write latency 1 edge: a load of the same address in the next cycle returns the new data.
- CYCLE read returns the pre-increment value of that cycle.
- Reset (rst low, asynchronous) values:
  - CYCLE=0, OUT=0, STATUS=0, LOADS=0, STORES=0.
  - out_port=0, status=0.
  - mem_read_data and access_err depend only on inputs; both are 0 when the enables are low.
- Reset asserted mid-store: the store is lost if rst is low at the edge. RAM keeps its prior contents.
- No backpressure: every request completes in its own cycle.

## Configuration
- DMEM_PERF_CNT_EN defined:
  - LOADS (0x0C) counts cycles with a valid aligned mapped read.
  - STORES (0x10) counts the same for writes. A collision increments both.
  - Both are RO and wrap at 2^32.
- Not defined: counters are absent, 0x0C/0x10 read 0, no extra flops.

## Structure
- Shared package dmem_pkg:
  - MMIO offset constants (OFS_CYCLE, OFS_OUT, OFS_STATUS, OFS_LOADS, OFS_STORES).
  - Status bit indices (ST_MISALIGN=0, ST_UNMAPPED=1, ST_COLLIDE=2).
  - Default MMIO_BASE.
- One sub-module, dmem_mmio_regs: holds CYCLE/OUT/STATUS/perf counters and the read mux for the window. The top level does decode, RAM and the final read mux.

## Test plan
- Reset, then store 0xDEADBEEF to 0x0000_0010, load 0x10 next cycle → mem_read_data=0xDEADBEEF; access_err=0.
- Load from 0x0000_0013 → mem_read_data=0, access_err=1, status=3'b001 after the edge. Write 0x1 to STATUS → status=0.
- Store 0x55 to OUT (MMIO_BASE+4) → out_port=0x55 after one edge. Store 0xAA to 0x0010_0000 (unmapped, ADDR_WIDTH=10) → status[1]=1, out_port unchanged.
- Hold idle 100 cycles after reset release, load CYCLE → 100. Preload CYCLE to 0xFFFF_FFFF via force → reads 0 one cycle later.
- Assert both enables on 0x20 holding 0x1, writing 0x2 → read returns 0x1, status[2]=1; next load returns 0x2.
- With DMEM_PERF_CNT_EN: 3 loads, 2 stores, 1 misaligned load → LOADS=3 (the LOADS read itself counts after its edge), STORES=2. Without the macro, 0x0C reads 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the data-memory responder and its register window
package dmem_pkg;

    // Byte offsets inside the 32-byte register window
    localparam logic [4:0] OFS_CYCLE  = 5'h00;
    localparam logic [4:0] OFS_OUT    = 5'h04;
    localparam logic [4:0] OFS_STATUS = 5'h08;
    localparam logic [4:0] OFS_LOADS  = 5'h0C;
    localparam logic [4:0] OFS_STORES = 5'h10;

    // Sticky error bit positions in STATUS
    localparam int ST_MISALIGN = 0;
    localparam int ST_UNMAPPED = 1;
    localparam int ST_COLLIDE  = 2;

    localparam logic [31:0] DEF_MMIO_BASE = 32'hFFFF_0000;

endpackage

// File: rtl/dmem_mmio_regs.sv
// dmem_mmio_regs: CYCLE/OUT/STATUS registers, optional LOADS/STORES counters (DMEM_PERF_CNT_EN) and window read mux
module dmem_mmio_regs
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  offset,
    input  logic        write_en,
    input  logic [31:0] write_data,
    input  logic [2:0]  err_set,
    input  logic        load_hit,
    input  logic        store_hit,
    output logic [31:0] read_data,
    output logic [31:0] out_port,
    output logic [2:0]  status
);

    logic [31:0] cycle;
    logic [31:0] perf_data;
    logic [2:0]  status_clr;

    assign status_clr = (write_en && offset == OFS_STATUS) ? write_data[2:0] : 3'b000;

    // Free-running cycle counter, OUT register and sticky status (set beats clear)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle    <= 32'd0;
            out_port <= 32'd0;
            status   <= 3'b000;
        end else begin
            cycle  <= cycle + 32'd1;
            status <= (status & ~status_clr) | err_set;
            if (write_en && offset == OFS_OUT)
                out_port <= write_data;
        end
    end

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] loads;
    logic [31:0] stores;

    // Count valid aligned mapped accesses; a collision bumps both
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            loads  <= 32'd0;
            stores <= 32'd0;
        end else begin
            if (load_hit)
                loads <= loads + 32'd1;
            if (store_hit)
                stores <= stores + 32'd1;
        end
    end

    assign perf_data = (offset == OFS_LOADS)  ? loads  :
                       (offset == OFS_STORES) ? stores : 32'd0;
`else
    logic unused_perf;
    assign unused_perf = load_hit ^ store_hit;
    assign perf_data   = 32'd0;
`endif

    assign read_data = (offset == OFS_CYCLE)  ? cycle            :
                       (offset == OFS_OUT)    ? out_port         :
                       (offset == OFS_STATUS) ? {29'd0, status}  : perf_data;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: CPU data-port responder with word RAM and MMIO window; perf counters under DMEM_PERF_CNT_EN
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] MMIO_BASE  = DEF_MMIO_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        access_err,
    output logic [31:0] out_port,
    output logic [2:0]  status
);

    logic [31:0]           ram [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] word;
    logic                  ram_hit;
    logic                  mmio_hit;
    logic                  aligned;
    logic                  rd_ok;
    logic                  wr_ok;
    logic [2:0]            err_set;
    logic [31:0]           mmio_rdata;

    assign word     = data_addr[ADDR_WIDTH+1:2];
    assign ram_hit  = (data_addr >> (ADDR_WIDTH + 2)) == 32'd0;
    assign mmio_hit = data_addr[31:5] == MMIO_BASE[31:5];
    assign aligned  = data_addr[1:0] == 2'b00;
    assign rd_ok    = mem_read_en  && aligned && (ram_hit || mmio_hit);
    assign wr_ok    = mem_write_en && aligned && (ram_hit || mmio_hit);

    // Classify the current access into the sticky error bits
    always_comb begin
        err_set              = 3'b000;
        err_set[ST_MISALIGN] = (mem_read_en || mem_write_en) && !aligned;
        err_set[ST_UNMAPPED] = (mem_read_en || mem_write_en) && aligned && !ram_hit && !mmio_hit;
        err_set[ST_COLLIDE]  = mem_read_en && mem_write_en;
    end

    assign access_err = |err_set;

    // RAM write; gating on rst drops a store whose edge lands inside reset
    always_ff @(posedge clk) begin
        if (rst && wr_ok && ram_hit)
            ram[word] <= mem_write_data;
    end

    dmem_mmio_regs u_regs (
        .clk        (clk),
        .rst        (rst),
        .offset     (data_addr[4:0]),
        .write_en   (wr_ok && mmio_hit),
        .write_data (mem_write_data),
        .err_set    (err_set),
        .load_hit   (rd_ok),
        .store_hit  (wr_ok),
        .read_data  (mmio_rdata),
        .out_port   (out_port),
        .status     (status)
    );

    assign mem_read_data = !rd_ok  ? 32'd0     :
                           ram_hit ? ram[word] : mmio_rdata;

endmodule
